// File: rtl/mms_io_master.sv
// MMS bus I/O master: arbitrates for the bus, then runs one IORC/IOWC cycle
// with programmable setup, hold and XACK timeout.
module mms_io_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        MMS_BCLK,
  input  logic        MMS_INIT,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        MMS_BREQ_o,
  input  logic        MMS_BPRN,
  output logic [23:0] MMS_ADR_o,
  output logic        MMS_ADR_oe,
  input  logic [15:0] MMS_DATA_i,
  output logic [15:0] MMS_DATA_o,
  output logic        MMS_DATA_oe,
  output logic        MMS_IORC_o,
  output logic        MMS_IOWC_o,
  output logic        MMS_CMD_oe,
  input  logic        MMS_XACK
);

  typedef enum logic [2:0] {IDLE, ARB, SETUP, CMD, HOLD, DONE} state_t;

  localparam logic [9:0] SETUP_LAST = 10'(SETUP_CYC - 1);
  localparam logic [9:0] HOLD_LAST  = 10'(HOLD_CYC - 1);
  localparam logic [9:0] TO_LAST    = 10'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;
  logic [9:0]  cnt, cnt_nx;
  logic        we_q, we_nx;
  logic [15:0] addr_q, addr_nx;
  logic [7:0]  wdata_q, wdata_nx;
  logic [7:0]  rdata_q, rdata_nx;
  logic        err_q, err_nx;
  logic        rdy;
  logic        on_bus;

  always_ff @(posedge MMS_BCLK or negedge MMS_INIT) begin
    if (!MMS_INIT) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
      rdy     <= 1'b1;
    end
  end

  // rdy keeps the first edge after reset release from accepting a request
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    we_nx    = we_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (req && rdy) begin
          we_nx    = we;
          addr_nx  = addr;
          wdata_nx = wdata;
          err_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = ARB;
        end
      end
      ARB: begin
        if (!MMS_BPRN) begin
          cnt_nx   = '0;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nx   = '0;
          state_nx = CMD;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      CMD: begin
        // XACK takes priority so a same-edge timeout still counts as success
        if (!MMS_XACK) begin
          err_nx   = 1'b0;
          if (!we_q) rdata_nx = MMS_DATA_i[7:0];
          cnt_nx   = '0;
          state_nx = HOLD;
        end else if (cnt == TO_LAST) begin
          err_nx   = 1'b1;
          if (!we_q) rdata_nx = 8'hFF;
          cnt_nx   = '0;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset releases them at once
  assign on_bus      = (state == SETUP) || (state == CMD) || (state == HOLD);
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign MMS_BREQ_o  = ~busy;
  assign MMS_ADR_o   = ~{8'h00, addr_q};
  assign MMS_ADR_oe  = on_bus;
  assign MMS_DATA_o  = {8'h00, wdata_q};
  assign MMS_DATA_oe = on_bus && we_q;
  assign MMS_CMD_oe  = on_bus;
  assign MMS_IORC_o  = ~((state == CMD) && !we_q);
  assign MMS_IOWC_o  = ~((state == CMD) && we_q);

endmodule

// File: tb/tb_mms_io_master.sv
// Directed bench for mms_io_master: transaction table plus reset/arbitration corner sequences.
module tb_mms_io_master;

  logic        clk = 1'b0;
  logic        MMS_INIT, req, we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy, done, err;
  logic [7:0]  rdata;
  logic        MMS_BREQ_o, MMS_BPRN;
  logic [23:0] MMS_ADR_o;
  logic        MMS_ADR_oe;
  logic [15:0] MMS_DATA_i, MMS_DATA_o;
  logic        MMS_DATA_oe, MMS_IORC_o, MMS_IOWC_o, MMS_CMD_oe, MMS_XACK;

  int n_cmp = 0;
  int n_err = 0;
  int cmd_low_cnt = 0;
  bit rd_active = 1'b0;

  always #5 clk = ~clk;

  mms_io_master #(.SETUP_CYC(2), .HOLD_CYC(1), .TIMEOUT_CYC(8)) dut (
    .MMS_BCLK(clk), .MMS_INIT(MMS_INIT), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .MMS_BREQ_o(MMS_BREQ_o), .MMS_BPRN(MMS_BPRN), .MMS_ADR_o(MMS_ADR_o),
    .MMS_ADR_oe(MMS_ADR_oe), .MMS_DATA_i(MMS_DATA_i), .MMS_DATA_o(MMS_DATA_o),
    .MMS_DATA_oe(MMS_DATA_oe), .MMS_IORC_o(MMS_IORC_o), .MMS_IOWC_o(MMS_IOWC_o),
    .MMS_CMD_oe(MMS_CMD_oe), .MMS_XACK(MMS_XACK)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus-protocol invariants watched on every cycle a command is low
  always @(negedge clk) begin
    if (MMS_INIT && (!MMS_IORC_o || !MMS_IOWC_o)) begin
      cmd_low_cnt++;
      chk("cmd_exclusive", 32'(MMS_IORC_o ^ MMS_IOWC_o), 32'd1);
      chk("cmd_adr_oe", 32'({MMS_ADR_oe, MMS_CMD_oe}), 32'b11);
    end
    if (rd_active) chk("rd_data_oe", 32'(MMS_DATA_oe), 32'd0);
  end

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          gdly;     // cycles BPRN stays high in ARB
    int          xd;       // edges after command start before XACK drive; -1 = never
    bit          early;    // XACK pulse during SETUP
    logic [7:0]  din;
    int          exp_low;
    bit          exp_err;
    logic [7:0]  exp_rdata;
    logic [23:0] exp_adr;
  } txn_t;

  txn_t tbl[7];

  task automatic run_txn(input txn_t t);
    int k;
    cmd_low_cnt = 0;
    req = 1'b1; we = t.we; addr = t.addr; wdata = t.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    rd_active = !t.we;
    chk("accept", 32'({busy, MMS_BREQ_o}), 32'b10);
    for (int i = 0; i < t.gdly; i++) begin
      @(posedge clk); #1;
      chk("arb_wait", 32'({MMS_BREQ_o, MMS_ADR_oe, MMS_DATA_oe, MMS_CMD_oe, MMS_IORC_o, MMS_IOWC_o}), 32'b000011);
    end
    MMS_BPRN = 1'b0;
    k = 0;
    while (k < 12) begin
      @(posedge clk); #1;
      k++;
      MMS_XACK = !(t.early && k == 1);
      if (!MMS_IORC_o || !MMS_IOWC_o) break;
    end
    chk("setup_latency", 32'(k), 32'd3);
    chk("cmd_kind", 32'({MMS_IORC_o, MMS_IOWC_o}), t.we ? 32'b10 : 32'b01);
    chk("adr_bus", 32'(MMS_ADR_o), 32'(t.exp_adr));
    chk("data_oe", 32'(MMS_DATA_oe), 32'(t.we));
    if (t.we) chk("data_bus", 32'(MMS_DATA_o), 32'({8'h00, t.wdata}));
    MMS_DATA_i = {8'h00, t.din};
    if (t.xd >= 0) begin
      repeat (t.xd) @(posedge clk);
      #1 MMS_XACK = 1'b0;
      @(posedge clk); #1;
      MMS_XACK = 1'b1;
      chk("cmd_release", 32'({MMS_IORC_o, MMS_IOWC_o, MMS_ADR_oe}), 32'b111);
    end
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_err", 32'(err), 32'(t.exp_err));
    chk("done_rdata", 32'(rdata), 32'(t.exp_rdata));
    chk("done_bus_off", 32'({MMS_BREQ_o, MMS_ADR_oe, MMS_DATA_oe, MMS_CMD_oe}), 32'b1000);
    chk("cmd_len", 32'(cmd_low_cnt), 32'(t.exp_low));
    rd_active = 1'b0;
    MMS_BPRN = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", 32'({done, busy}), 32'b00);
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0400, 8'hA5, 0,  3, 1'b0, 8'h00, 4, 1'b0, 8'h00, 24'hFFFBFF};
    tbl[1] = '{1'b0, 16'h0400, 8'h00, 0,  3, 1'b0, 8'h3C, 4, 1'b0, 8'h3C, 24'hFFFBFF};
    tbl[2] = '{1'b0, 16'h1234, 8'h00, 0, -1, 1'b0, 8'h12, 8, 1'b1, 8'hFF, 24'hFFEDCB};
    tbl[3] = '{1'b0, 16'h00FF, 8'h00, 10, 0, 1'b0, 8'h5A, 1, 1'b0, 8'h5A, 24'hFFFF00};
    tbl[4] = '{1'b1, 16'hABCD, 8'h3C, 0,  2, 1'b1, 8'h99, 3, 1'b0, 8'h5A, 24'hFF5432};
    tbl[5] = '{1'b0, 16'h0001, 8'h00, 0,  7, 1'b0, 8'h81, 8, 1'b0, 8'h81, 24'hFFFFFE};
    tbl[6] = '{1'b0, 16'h0002, 8'h00, 0,  6, 1'b0, 8'h7E, 7, 1'b0, 8'h7E, 24'hFFFFFD};

    MMS_INIT = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    MMS_BPRN = 1'b1; MMS_XACK = 1'b1; MMS_DATA_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({busy, done, err, rdata, MMS_BREQ_o, MMS_IORC_o, MMS_IOWC_o,
                            MMS_ADR_oe, MMS_DATA_oe, MMS_CMD_oe}), 32'b000_00000000_111_000);

    // Request held across reset release: first edge ignored, second accepts
    MMS_INIT = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h0400;
    @(posedge clk); #1;
    chk("init_first_edge", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("init_second_edge", 32'({busy, MMS_BREQ_o}), 32'b10);
    req = 1'b0;
    MMS_INIT = 1'b0;
    #1;
    chk("reset_in_arb", 32'({busy, MMS_BREQ_o}), 32'b01);
    #2 MMS_INIT = 1'b1;
    @(posedge clk); #1;

    // Request held while busy must not disturb the latched transfer
    req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 8'h11;
    @(posedge clk); #1;
    chk("busy_accept", 32'(busy), 32'd1);
    addr = 16'h0020; we = 1'b0; wdata = 8'h22;
    MMS_BPRN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_ignore_cmd", 32'({MMS_IORC_o, MMS_IOWC_o}), 32'b10);
    chk("busy_ignore_adr", 32'(MMS_ADR_o), 32'hFFFFEF);
    chk("busy_ignore_data", 32'({MMS_DATA_oe, MMS_DATA_o}), 32'h1_0011);
    req = 1'b0;
    #1 MMS_INIT = 1'b0;
    #1;
    chk("reset_mid_cmd", 32'({MMS_IORC_o, MMS_IOWC_o, MMS_ADR_oe, MMS_DATA_oe, MMS_CMD_oe, busy, MMS_BREQ_o}),
        32'b1100001);
    #3 MMS_INIT = 1'b1;
    MMS_BPRN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mms_io_master.md
MMS_IO_MASTER -- requirements
Module: mms_io_master

Interface
REQ-001 Parameter SETUP_CYC, default 2: BCLK cycles from address/data valid to command assertion, legal range 1-15.
REQ-002 Parameter HOLD_CYC, default 1: BCLK cycles that address/data stay valid after the command is released, legal range 1-15.
REQ-003 Parameter TIMEOUT_CYC, default 255: BCLK cycles the command may stay asserted without XACK, legal range 2-1023.
REQ-004 MMS_BCLK  in  1  sole clock; all logic on its rising edge.
REQ-005 MMS_INIT  in  1  reset, asynchronous, active-low.
REQ-006 req  in  1  local request strobe; sampled only in IDLE.
REQ-007 we  in  1  1 = I/O write (IOWC), 0 = I/O read (IORC).
REQ-008 addr  in  16  I/O port address.
REQ-009 wdata  in  8  write data.
REQ-010 busy  out  1  high from request acceptance until done.
REQ-011 done  out  1  one-cycle pulse at transfer end.
REQ-012 err  out  1  valid with done; 1 = XACK timeout.
REQ-013 rdata  out  8  read data, valid from done until the next acceptance.
REQ-014 MMS_BREQ_o  out  1  active-low bus request.
REQ-015 MMS_BPRN  in  1  active-low bus priority grant.
REQ-016 MMS_ADR_o / MMS_ADR_oe  out  24 / 1  bus address, inverted polarity, plus drive enable.
REQ-017 MMS_DATA_i / MMS_DATA_o / MMS_DATA_oe  in / out / out  16 / 16 / 1  bus data, true polarity, plus drive enable.
REQ-018 MMS_IORC_o / MMS_IOWC_o  out  1 each  active-low read and write commands; 1 when idle.
REQ-019 MMS_CMD_oe  out  1  drive enable for IORC and IOWC.
REQ-020 MMS_XACK  in  1  active-low transfer acknowledge.

Function
REQ-021 FSM states SHALL be IDLE, ARB, SETUP, CMD, HOLD, DONE.
REQ-022 IDLE: when req=1, the block SHALL latch we/addr/wdata, set busy=1, drive MMS_BREQ_o=0 and go to ARB; req=1 in any other state SHALL be ignored.
REQ-023 ARB: the block SHALL wait for MMS_BPRN=0, then enable the address and data drivers and go to SETUP; there is no timeout in ARB.
REQ-024 Address SHALL be driven as ~{8'h00, addr}; for example, port 0x0400 appears on the bus as 24'hFFFBFF.
REQ-025 Write data SHALL be driven as {8'h00, wdata} with MMS_DATA_oe=1 from SETUP through HOLD, for writes only; reads SHALL keep MMS_DATA_oe=0 throughout.
REQ-026 SETUP: the block SHALL stay exactly SETUP_CYC cycles, then assert IORC or IOWC low (per we) and go to CMD.
REQ-027 CMD: the command SHALL stay asserted until MMS_XACK is sampled 0 or the cycle counter reaches TIMEOUT_CYC.
REQ-028 On XACK=0 during a read, rdata SHALL capture MMS_DATA_i[7:0] on that same edge, and err SHALL be 0.
REQ-029 On timeout, err SHALL be 1 and a read SHALL load rdata=8'hFF.
REQ-030 When CMD ends for either cause, the command SHALL deassert on the next cycle and the FSM SHALL go to HOLD.
REQ-031 HOLD: address and data SHALL remain driven for HOLD_CYC cycles, after which all oe signals SHALL drop to 0, MMS_BREQ_o SHALL go to 1, and the FSM SHALL go to DONE.
REQ-032 DONE: done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE; a new req SHALL be accepted no earlier than the cycle after DONE.
REQ-033 XACK=0 seen in IDLE, ARB, SETUP or HOLD SHALL be ignored.
REQ-034 XACK=0 and timeout on the same edge SHALL count as a success (err=0).
REQ-035 IORC and IOWC SHALL never be low simultaneously.
REQ-036 Neither command SHALL be low while MMS_ADR_oe=0.

Reset
REQ-037 While MMS_INIT=0, the block SHALL force state=IDLE, busy=0, done=0, err=0, rdata=8'h00, MMS_BREQ_o=1, MMS_IORC_o=1, MMS_IOWC_o=1, all oe=0, and clear all counters; this SHALL take effect asynchronously, including mid-transfer.
REQ-038 After MMS_INIT deasserts, the first request SHALL be accepted no earlier than the second rising edge.

Verification
REQ-039 Write: req, we=1, addr=0x0400, wdata=0xA5; grant at once; XACK low 3 cycles after IOWC -> bus carries ADR=FFFBFF and DATA=00A5; IOWC low 4 cycles; done with err=0.
REQ-040 Read: addr=0x0400; responder returns 0x3C with XACK -> rdata=0x3C, err=0, MMS_DATA_oe=0 throughout.
REQ-041 Timeout: read with XACK never asserted -> IORC low for exactly TIMEOUT_CYC cycles, then done with err=1 and rdata=0xFF.
REQ-042 Arbitration: BPRN held high 10 cycles -> BREQ_o=0 the whole time, no oe asserted, no command; transfer completes normally after grant.
REQ-043 Reset mid-CMD: MMS_INIT=0 while IOWC is low -> IOWC=1 and all oe=0 before the next clock edge; a req after release completes normally.
REQ-044 Boundaries: req while busy is ignored; XACK in SETUP does not shorten the command; XACK and timeout on the same edge gives err=0; IORC and IOWC are never low together.
